// File: rtl/chan_edge_counter_if.sv
// ----------------------------------------------------------------------------
// chan_edge_counter_if
// Read handshake bundle for chan_edge_counter (two-signal four-phase read).
//   rd_sel   [1:0]      channel to read, sampled only when a read is accepted
//   rd_req              read request, level held by the requester
//   rd_valid            rd_data is valid; held until rd_req drops
//   rd_data  [CNT_W-1:0] captured count of the selected channel
// master: the requester (test/debug path); slave: chan_edge_counter.
// ----------------------------------------------------------------------------
interface chan_edge_counter_if #(
  parameter int CNT_W = 4
);
  logic [1:0]       rd_sel;
  logic             rd_req;
  logic             rd_valid;
  logic [CNT_W-1:0] rd_data;

  modport master (
    output rd_sel,
    output rd_req,
    input  rd_valid,
    input  rd_data
  );

  modport slave (
    input  rd_sel,
    input  rd_req,
    output rd_valid,
    output rd_data
  );
endinterface

// File: rtl/chan_edge_counter.sv
// ----------------------------------------------------------------------------
// chan_edge_counter
// Counts rising edges on the four routed channels in wrapping per-channel
// counters with sticky per-channel overflow flags, and returns one channel's
// count through a registered four-phase read handshake.
//
// Ports:
//   clk           single clock, rising edge
//   rst           synchronous reset, active-high
//   in0..in3      channel inputs from the routing stage (synchronous to clk)
//   clr           synchronous clear of all counters and overflow flags
//   ovf   [3:0]   sticky wrap flags, bit i belongs to in_i
//   rd            read handshake (chan_edge_counter_if.slave)
//
// Parameters:
//   CNT_W         counter and rd_data width (default 4)
//
// Build option:
//   CHAN_EDGE_RDCLR_EN  when defined, a read clears the selected channel's
//                       counter and overflow flag at the capture edge
//                       (an edge arriving in that same cycle is kept as 1).
//                       When undefined, reads are non-destructive.
// ----------------------------------------------------------------------------
module chan_edge_counter #(
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in0,
  input  logic                 in1,
  input  logic                 in2,
  input  logic                 in3,
  input  logic                 clr,
  output logic [3:0]           ovf,
  chan_edge_counter_if.slave   rd
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [3:0]       in_vec;
  logic [3:0]       prev_q;
  logic [3:0]       edge_v;
  logic [CNT_W-1:0] cnt_q [4];
  logic [1:0]       sel_q;
  logic             accept;
  logic             capture;
  logic             release_rd;

  assign in_vec = {in3, in2, in1, in0};
  assign edge_v = in_vec & ~prev_q;

  // prev_q tracks the inputs in reset as well, so a channel that is already
  // high when reset releases does not register a rising edge.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    prev_q <= in_vec;
  end

  // --------------------------------------------------------------------------
  // Read FSM: next state and one-cycle strobes
  // --------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    capture    = 1'b0;
    release_rd = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rd.rd_req) begin
          accept  = 1'b1;
          state_d = LATCH;
        end
      end
      LATCH: begin
        capture = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (!rd.rd_req) begin
          release_rd = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= 2'd0;
      rd.rd_valid <= 1'b0;
      rd.rd_data  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sel_q <= rd.rd_sel;
      end
      // cnt_q is read before this edge's update, so the capture is the
      // pre-update (and pre-clear) count.
      if (capture) begin
        rd.rd_data  <= cnt_q[sel_q];
        rd.rd_valid <= 1'b1;
      end
      if (release_rd) begin
        rd.rd_valid <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel counters and sticky overflow flags
  // --------------------------------------------------------------------------
  // NOTE: the counter array is only four registers wide, so it is reset like
  // ordinary flops; it is not a RAM and needs no init sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
      ovf <= 4'b0000;
    end else if (clr) begin
      // clr wins over any coincident edge: the edge is dropped.
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
      ovf <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
`ifdef CHAN_EDGE_RDCLR_EN
        if (capture && (sel_q == 2'(i))) begin
          // Read-and-clear: an edge in the capture cycle survives as 1.
          cnt_q[i] <= CNT_W'(edge_v[i]);
          ovf[i]   <= 1'b0;
        end else if (edge_v[i]) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          if (&cnt_q[i]) begin
            ovf[i] <= 1'b1;
          end
        end
`else
        if (edge_v[i]) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          // Wrap from all-ones to zero sets the sticky flag.
          if (&cnt_q[i]) begin
            ovf[i] <= 1'b1;
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_chan_edge_counter.sv
// ----------------------------------------------------------------------------
// tb_chan_edge_counter
// Directed stimulus against chan_edge_counter. A behavioural model counts
// rising-edge events per channel as plain integers (count = events mod 2^CNT_W,
// overflow = events >= 2^CNT_W) and tracks the read handshake; a compare
// process checks rd_valid, rd_data and ovf against it on every falling edge.
// Directed checks with literal expectations pin the model.
// Honours CHAN_EDGE_RDCLR_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_chan_edge_counter;

  localparam int CNT_W = 4;
  localparam int MOD   = 1 << CNT_W;
`ifdef CHAN_EDGE_RDCLR_EN
  localparam bit RDCLR = 1'b1;
`else
  localparam bit RDCLR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ins;
  logic       clr;
  logic [3:0] ovf;

  int n_checks = 0;
  int n_fail   = 0;

  chan_edge_counter_if #(.CNT_W(CNT_W)) rd_if ();

  chan_edge_counter #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .in0 (ins[0]),
    .in1 (ins[1]),
    .in2 (ins[2]),
    .in3 (ins[3]),
    .clr (clr),
    .ovf (ovf),
    .rd  (rd_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model
  // --------------------------------------------------------------------------
  int               ev [4];     // rising edges seen since last clear
  logic [3:0]       m_prev;
  int               m_phase;    // 0 no read, 1 accepted, 2 data returned
  logic [1:0]       m_sel;
  logic             m_valid;
  logic [CNT_W-1:0] m_data;
  bit               model_ok = 1'b0;

  function automatic logic [3:0] m_ovf();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (ev[i] >= MOD);
    return r;
  endfunction

  always @(posedge clk) begin
    logic [3:0] e;
    bit         cap;
    if (rst) begin
      for (int i = 0; i < 4; i++) ev[i] = 0;
      m_prev   = ins;
      m_phase  = 0;
      m_sel    = 2'd0;
      m_valid  = 1'b0;
      m_data   = '0;
      model_ok = 1'b1;
    end else begin
      e      = ins & ~m_prev;
      m_prev = ins;
      cap    = (m_phase == 1);
      if (m_phase == 0 && rd_if.rd_req) begin
        m_sel   = rd_if.rd_sel;
        m_phase = 1;
      end else if (m_phase == 1) begin
        m_data  = CNT_W'(ev[m_sel] % MOD);
        m_valid = 1'b1;
        m_phase = 2;
      end else if (m_phase == 2 && !rd_if.rd_req) begin
        m_valid = 1'b0;
        m_phase = 0;
      end
      for (int i = 0; i < 4; i++) begin
        if (clr)                              ev[i] = 0;
        else if (RDCLR && cap && m_sel == i)  ev[i] = int'(e[i]);
        else                                  ev[i] = ev[i] + int'(e[i]);
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("model rd_valid", 32'(rd_if.rd_valid), 32'(m_valid));
      check("model rd_data",  32'(rd_if.rd_data),  32'(m_data));
      check("model ovf",      32'(ovf),            32'(m_ovf()));
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (inputs change just after a falling edge)
  // --------------------------------------------------------------------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int ch, input int n);
    repeat (n) begin
      ins[ch] = 1'b1;
      tick();
      ins[ch] = 1'b0;
      tick();
    end
  endtask

  // Full read: valid must appear exactly two edges after rd_req rises,
  // and drop one edge after rd_req falls.
  task automatic do_read(input logic [1:0] sel, input logic [CNT_W-1:0] exp, input string name);
    rd_if.rd_sel = sel;
    rd_if.rd_req = 1'b1;
    tick();
    check({name, " valid after 1 edge"}, 32'(rd_if.rd_valid), 32'd0);
    tick();
    check({name, " valid after 2 edges"}, 32'(rd_if.rd_valid), 32'd1);
    check({name, " data"}, 32'(rd_if.rd_data), 32'(exp));
    rd_if.rd_req = 1'b0;
    tick();
    check({name, " valid released"}, 32'(rd_if.rd_valid), 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    ins          = 4'hF;
    clr          = 1'b0;
    rd_if.rd_req = 1'b0;
    rd_if.rd_sel = 2'd0;

    // Reset with all inputs high; they must not count after release.
    tick(3);
    check("reset rd_valid", 32'(rd_if.rd_valid), 32'd0);
    check("reset rd_data",  32'(rd_if.rd_data),  32'd0);
    check("reset ovf",      32'(ovf),            32'd0);
    rst = 1'b0;
    tick(5);
    for (int i = 0; i < 4; i++) do_read(2'(i), 4'd0, "held-high read");
    check("held-high ovf", 32'(ovf), 32'd0);
    ins = 4'h0;
    tick(2);

    // Three pulses on in2, then two more while HOLD keeps rd_data frozen.
    pulse(2, 3);
    rd_if.rd_sel = 2'd2;
    rd_if.rd_req = 1'b1;
    tick();
    check("in2 valid after 1 edge", 32'(rd_if.rd_valid), 32'd0);
    tick();
    check("in2 valid after 2 edges", 32'(rd_if.rd_valid), 32'd1);
    check("in2 data", 32'(rd_if.rd_data), 32'd3);
    pulse(2, 2);
    check("in2 data frozen", 32'(rd_if.rd_data), 32'd3);
    check("in2 valid held", 32'(rd_if.rd_valid), 32'd1);
    rd_if.rd_req = 1'b0;
    tick();
    check("in2 valid released", 32'(rd_if.rd_valid), 32'd0);

    // 17 pulses on in1 wrap the counter once.
    pulse(1, 17);
    check("in1 wrap ovf", 32'(ovf), 32'b0010);
    do_read(2'd1, 4'd1, "in1 wrap read");

    // clr with a coincident in1 edge: edge dropped, everything zero.
    ins[1] = 1'b1;
    clr    = 1'b1;
    tick();
    clr    = 1'b0;
    ins[1] = 1'b0;
    tick();
    check("clr ovf", 32'(ovf), 32'd0);
    do_read(2'd1, 4'd0, "clr in1 read");
    do_read(2'd2, 4'd0, "clr in2 read");

    // rd_sel change after acceptance is ignored.
    pulse(0, 2);
    pulse(3, 5);
    rd_if.rd_sel = 2'd0;
    rd_if.rd_req = 1'b1;
    tick();
    rd_if.rd_sel = 2'd3;
    tick();
    check("late sel valid", 32'(rd_if.rd_valid), 32'd1);
    check("late sel data",  32'(rd_if.rd_data),  32'd2);
    rd_if.rd_req = 1'b0;
    tick();
    check("late sel release", 32'(rd_if.rd_valid), 32'd0);

    // in3 edge in the capture cycle: captured value is pre-edge count.
    rd_if.rd_sel = 2'd3;
    rd_if.rd_req = 1'b1;
    tick();
    ins[3] = 1'b1;
    tick();
    check("latch-edge valid", 32'(rd_if.rd_valid), 32'd1);
    check("latch-edge data",  32'(rd_if.rd_data),  32'd5);
    ins[3]       = 1'b0;
    rd_if.rd_req = 1'b0;
    tick();
    check("latch-edge release", 32'(rd_if.rd_valid), 32'd0);
    do_read(2'd3, RDCLR ? 4'd1 : 4'd6, "second in3 read");

    // Reset in HOLD with rd_req held high.
    pulse(1, 16);
    check("pre-reset ovf", 32'(ovf), 32'b0010);
    rd_if.rd_sel = 2'd3;
    rd_if.rd_req = 1'b1;
    tick(2);
    check("hold before reset", 32'(rd_if.rd_valid), 32'd1);
    rst    = 1'b1;
    ins[3] = 1'b1;
    tick();
    check("mid-read reset valid", 32'(rd_if.rd_valid), 32'd0);
    check("mid-read reset data",  32'(rd_if.rd_data),  32'd0);
    check("mid-read reset ovf",   32'(ovf),            32'd0);
    rst = 1'b0;
    tick();
    check("post-reset valid 1 edge", 32'(rd_if.rd_valid), 32'd0);
    tick();
    check("post-reset valid 2 edges", 32'(rd_if.rd_valid), 32'd1);
    check("post-reset data", 32'(rd_if.rd_data), 32'd0);
    ins[3]       = 1'b0;
    rd_if.rd_req = 1'b0;
    tick();
    check("post-reset release", 32'(rd_if.rd_valid), 32'd0);
    pulse(0, 3);
    do_read(2'd0, 4'd3, "post-reset count read");

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
